// File: rtl/axis_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axis_tx_pkg
//  Description : Shared constants, state encoding and helpers for the
//                RDMA-to-Ethernet TX adapter (axis_tx_from_rdma).
//  Revision    : 1.0 - initial release
// ============================================================================
package axis_tx_pkg;

    // Number of 32-bit words in one TXC control packet.
    localparam int TXC_WORDS = 6;

    // TXC word 0: normal transmit, no checksum offload.
    localparam logic [31:0] TXC_FLAG_WORD_DEFAULT = 32'hA000_0000;

    // Adapter state encoding.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_TXC  = 2'd1;
    localparam state_t ST_DATA = 2'd2;
    localparam state_t ST_PAD  = 2'd3;

    // Number of valid bytes in a 4-bit keep vector (0..4).
    function automatic logic [2:0] keep_popcount(input logic [3:0] keep);
        return 3'(keep[0]) + 3'(keep[1]) + 3'(keep[2]) + 3'(keep[3]);
    endfunction

endpackage : axis_tx_pkg
`default_nettype wire

// File: rtl/axis_tx_from_rdma.sv
`default_nettype none
// ============================================================================
//  Module      : axis_tx_from_rdma
//  Description : Accepts complete Ethernet frames on an AXI-Stream slave and
//                drives the MAC TX control (TXC) and data (TXD) streams.
//                Each frame is preceded by a 6-word TXC packet; data beats go
//                through one registered stage; short frames are zero-padded
//                up to MIN_FRAME_BYTES. Completed frames are reported with a
//                pulse, their length and a running count.
//  Revision    : 1.0 - initial release
//
//  Ports
//    axis_clk / axis_aresetn     : clock, synchronous active-low reset
//    tx_enable                   : allows a new frame to start (IDLE only)
//    s_axis_t*                   : frame input from the RDMA encapsulator
//    m_axis_txc_t*               : TXC control stream to the MAC
//    m_axis_txd_t*               : TXD data stream to the MAC
//    frame_sent                  : 1-cycle pulse after the final TXD beat
//    frame_len_bytes             : byte count of the last frame (with pad)
//    frames_sent_cnt             : wrapping count of frames sent
// ============================================================================
module axis_tx_from_rdma
    import axis_tx_pkg::*;
#(
    parameter int          MIN_FRAME_BYTES = 60,
    parameter logic [31:0] TXC_FLAG_WORD   = TXC_FLAG_WORD_DEFAULT
) (
    input  logic        axis_clk,
    input  logic        axis_aresetn,
    input  logic        tx_enable,

    input  logic [31:0] s_axis_tdata,
    input  logic [3:0]  s_axis_tkeep,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,

    output logic [31:0] m_axis_txc_tdata,
    output logic [3:0]  m_axis_txc_tkeep,
    output logic        m_axis_txc_tvalid,
    input  logic        m_axis_txc_tready,
    output logic        m_axis_txc_tlast,

    output logic [31:0] m_axis_txd_tdata,
    output logic [3:0]  m_axis_txd_tkeep,
    output logic        m_axis_txd_tvalid,
    input  logic        m_axis_txd_tready,
    output logic        m_axis_txd_tlast,

    output logic        frame_sent,
    output logic [15:0] frame_len_bytes,
    output logic [31:0] frames_sent_cnt
);

    localparam logic [16:0] c_MIN_BYTES = 17'(MIN_FRAME_BYTES);
    localparam bit          c_PAD_EN    = (MIN_FRAME_BYTES != 0);
    localparam logic [2:0]  c_TXC_LAST  = 3'(TXC_WORDS - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [2:0]  r_txc_idx;
    logic [15:0] r_byte_cnt;
    // Final beat of the frame is sitting in the output stage; no more
    // input or pad words may be loaded until it handshakes.
    logic        r_drain;

    logic [31:0] r_txd_data;
    logic [3:0]  r_txd_keep;
    logic        r_txd_valid;
    logic        r_txd_last;

    logic        r_frame_sent;
    logic [15:0] r_frame_len;
    logic [31:0] r_frames_cnt;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    state_t      w_state_next;
    logic        w_out_free;
    logic        w_out_fire;
    logic        w_accept;
    logic        w_in_fire;
    logic        w_txc_fire;
    logic [16:0] w_sum17;
    logic [15:0] w_new_cnt;
    logic        w_short;
    logic [16:0] w_round17;
    logic [16:0] w_pad_sum17;
    logic        w_pad_last;
    logic [15:0] w_pad_cnt;
    logic        w_pad_load;
    logic [31:0] w_masked;

    assign w_out_free = !r_txd_valid || m_axis_txd_tready;
    assign w_out_fire = r_txd_valid && m_axis_txd_tready;
    assign w_accept   = (r_state == ST_DATA) && !r_drain && w_out_free;
    assign w_in_fire  = s_axis_tvalid && w_accept;
    assign w_txc_fire = (r_state == ST_TXC) && m_axis_txc_tready;

    // Saturating byte count including the current input beat.
    assign w_sum17   = {1'b0, r_byte_cnt} + 17'(keep_popcount(s_axis_tkeep));
    assign w_new_cnt = w_sum17[16] ? 16'hFFFF : w_sum17[15:0];
    assign w_short   = c_PAD_EN && ({1'b0, w_new_cnt} < c_MIN_BYTES);

    // The short last beat is widened to a full word, so round up to 4.
    assign w_round17 = ({1'b0, w_new_cnt} + 17'd3) & ~17'd3;

    // Pad words: the one reaching the minimum closes the frame. A short
    // frame whose rounded length already equals the minimum still needs
    // one pad word to carry tlast (the data beat had its tlast stripped);
    // the reported length is held at the minimum in that case.
    assign w_pad_sum17 = {1'b0, r_byte_cnt} + 17'd4;
    assign w_pad_last  = (w_pad_sum17 >= c_MIN_BYTES);
    assign w_pad_cnt   = w_pad_last ? c_MIN_BYTES[15:0] : w_pad_sum17[15:0];
    assign w_pad_load  = (r_state == ST_PAD) && !r_drain && w_out_free;

    always_comb begin
        w_masked = '0;
        for (int b = 0; b < 4; b++) begin
            if (s_axis_tkeep[b]) begin
                w_masked[8*b +: 8] = s_axis_tdata[8*b +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge axis_clk) begin
        if (!axis_aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and TXC outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next      = r_state;
        m_axis_txc_tvalid = 1'b0;
        m_axis_txc_tdata  = '0;
        m_axis_txc_tkeep  = '0;
        m_axis_txc_tlast  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (tx_enable && s_axis_tvalid) begin
                    w_state_next = ST_TXC;
                end
            end
            ST_TXC: begin
                m_axis_txc_tvalid = 1'b1;
                m_axis_txc_tkeep  = 4'hF;
                m_axis_txc_tdata  = (r_txc_idx == 3'd0) ? TXC_FLAG_WORD : 32'd0;
                m_axis_txc_tlast  = (r_txc_idx == c_TXC_LAST);
                if (m_axis_txc_tready && (r_txc_idx == c_TXC_LAST)) begin
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_in_fire && s_axis_tlast && w_short) begin
                    w_state_next = ST_PAD;
                end else if (r_drain && w_out_fire) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_PAD: begin
                if (r_drain && w_out_fire) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: TXC index, byte counter, TXD output stage, statistics
    // ------------------------------------------------------------------
    always_ff @(posedge axis_clk) begin
        if (!axis_aresetn) begin
            r_txc_idx    <= '0;
            r_byte_cnt   <= '0;
            r_drain      <= 1'b0;
            r_txd_data   <= '0;
            r_txd_keep   <= '0;
            r_txd_valid  <= 1'b0;
            r_txd_last   <= 1'b0;
            r_frame_sent <= 1'b0;
            r_frame_len  <= '0;
            r_frames_cnt <= '0;
        end else begin
            r_frame_sent <= 1'b0;

            if (w_out_fire) begin
                r_txd_valid <= 1'b0;
            end

            if (w_out_fire && r_txd_last) begin
                r_frame_sent <= 1'b1;
                r_frame_len  <= r_byte_cnt;
                r_frames_cnt <= r_frames_cnt + 32'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    r_byte_cnt <= '0;
                    r_drain    <= 1'b0;
                    r_txc_idx  <= '0;
                end
                ST_TXC: begin
                    if (w_txc_fire) begin
                        r_txc_idx <= (r_txc_idx == c_TXC_LAST) ? 3'd0
                                                               : r_txc_idx + 3'd1;
                    end
                end
                ST_DATA: begin
                    if (w_in_fire) begin
                        r_txd_valid <= 1'b1;
                        if (s_axis_tlast && w_short) begin
                            r_txd_data <= w_masked;
                            r_txd_keep <= 4'hF;
                            r_txd_last <= 1'b0;
                            r_byte_cnt <= w_round17[15:0];
                        end else begin
                            r_txd_data <= s_axis_tdata;
                            r_txd_keep <= s_axis_tkeep;
                            r_txd_last <= s_axis_tlast;
                            r_byte_cnt <= w_new_cnt;
                            r_drain    <= s_axis_tlast;
                        end
                    end
                end
                ST_PAD: begin
                    if (w_pad_load) begin
                        r_txd_valid <= 1'b1;
                        r_txd_data  <= '0;
                        r_txd_keep  <= 4'hF;
                        r_txd_last  <= w_pad_last;
                        r_byte_cnt  <= w_pad_cnt;
                        r_drain     <= w_pad_last;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_axis_tready     = w_accept;
    assign m_axis_txd_tdata  = r_txd_data;
    assign m_axis_txd_tkeep  = r_txd_keep;
    assign m_axis_txd_tvalid = r_txd_valid;
    assign m_axis_txd_tlast  = r_txd_last;
    assign frame_sent        = r_frame_sent;
    assign frame_len_bytes   = r_frame_len;
    assign frames_sent_cnt   = r_frames_cnt;

endmodule : axis_tx_from_rdma
`default_nettype wire

// File: tb/tb_axis_tx_from_rdma.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_tx_from_rdma
//  Description : Self-checking bench for axis_tx_from_rdma. Frames are
//                compared against a byte-level model of the transmit rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_tx_from_rdma;

    localparam int MIN = 60;

    logic        axis_clk = 1'b0;
    logic        axis_aresetn;
    logic        tx_enable;
    logic [31:0] s_axis_tdata;
    logic [3:0]  s_axis_tkeep;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [31:0] m_axis_txc_tdata;
    logic [3:0]  m_axis_txc_tkeep;
    logic        m_axis_txc_tvalid;
    logic        m_axis_txc_tready;
    logic        m_axis_txc_tlast;
    logic [31:0] m_axis_txd_tdata;
    logic [3:0]  m_axis_txd_tkeep;
    logic        m_axis_txd_tvalid;
    logic        m_axis_txd_tready;
    logic        m_axis_txd_tlast;
    logic        frame_sent;
    logic [15:0] frame_len_bytes;
    logic [31:0] frames_sent_cnt;

    axis_tx_from_rdma #(
        .MIN_FRAME_BYTES (MIN),
        .TXC_FLAG_WORD   (32'hA000_0000)
    ) dut (
        .axis_clk          (axis_clk),
        .axis_aresetn      (axis_aresetn),
        .tx_enable         (tx_enable),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tkeep      (s_axis_tkeep),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tready     (s_axis_tready),
        .s_axis_tlast      (s_axis_tlast),
        .m_axis_txc_tdata  (m_axis_txc_tdata),
        .m_axis_txc_tkeep  (m_axis_txc_tkeep),
        .m_axis_txc_tvalid (m_axis_txc_tvalid),
        .m_axis_txc_tready (m_axis_txc_tready),
        .m_axis_txc_tlast  (m_axis_txc_tlast),
        .m_axis_txd_tdata  (m_axis_txd_tdata),
        .m_axis_txd_tkeep  (m_axis_txd_tkeep),
        .m_axis_txd_tvalid (m_axis_txd_tvalid),
        .m_axis_txd_tready (m_axis_txd_tready),
        .m_axis_txd_tlast  (m_axis_txd_tlast),
        .frame_sent        (frame_sent),
        .frame_len_bytes   (frame_len_bytes),
        .frames_sent_cnt   (frames_sent_cnt)
    );

    initial forever #5 axis_clk = ~axis_clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          exp_frames = 0;
    bit          rnd_rdy  = 1'b0;
    logic [36:0] txc_q[$];
    logic [36:0] txd_q[$];
    logic [47:0] sent_q[$];
    int          sent_dly_q[$];
    logic [31:0] in_q[$];
    int          stab_viol    = 0;
    int          overlap_viol = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ready generator: all-high or 50% random per cycle.
    initial begin
        m_axis_txc_tready = 1'b1;
        m_axis_txd_tready = 1'b1;
        forever begin
            @(posedge axis_clk);
            #1;
            if (rnd_rdy) begin
                m_axis_txc_tready = 1'($urandom_range(0, 1));
                m_axis_txd_tready = 1'($urandom_range(0, 1));
            end else begin
                m_axis_txc_tready = 1'b1;
                m_axis_txd_tready = 1'b1;
            end
        end
    end

    // Output monitor: records handshakes, checks AXIS stability and exclusivity.
    initial begin
        bit          txd_stall = 1'b0;
        bit          txc_stall = 1'b0;
        logic [36:0] txd_hold  = '0;
        logic [36:0] txc_hold  = '0;
        int          last_tlast_cyc = 0;
        forever begin
            @(negedge axis_clk);
            cyc++;
            if (!axis_aresetn) begin
                txd_stall = 1'b0;
                txc_stall = 1'b0;
            end else begin
                if (m_axis_txc_tvalid && m_axis_txd_tvalid) overlap_viol++;
                if (txd_stall && (!m_axis_txd_tvalid ||
                    {m_axis_txd_tlast, m_axis_txd_tkeep, m_axis_txd_tdata} != txd_hold)) stab_viol++;
                if (txc_stall && (!m_axis_txc_tvalid ||
                    {m_axis_txc_tlast, m_axis_txc_tkeep, m_axis_txc_tdata} != txc_hold)) stab_viol++;
                txd_stall = m_axis_txd_tvalid && !m_axis_txd_tready;
                txc_stall = m_axis_txc_tvalid && !m_axis_txc_tready;
                txd_hold  = {m_axis_txd_tlast, m_axis_txd_tkeep, m_axis_txd_tdata};
                txc_hold  = {m_axis_txc_tlast, m_axis_txc_tkeep, m_axis_txc_tdata};
                if (m_axis_txc_tvalid && m_axis_txc_tready) txc_q.push_back(txc_hold);
                if (m_axis_txd_tvalid && m_axis_txd_tready) begin
                    txd_q.push_back(txd_hold);
                    if (m_axis_txd_tlast) last_tlast_cyc = cyc;
                end
                if (frame_sent) begin
                    sent_q.push_back({frame_len_bytes, frames_sent_cnt});
                    sent_dly_q.push_back(cyc - last_tlast_cyc);
                end
            end
        end
    end

    function automatic logic [3:0] keep_of(input int len);
        if (len % 4 == 0) return 4'hF;
        return 4'((1 << (len % 4)) - 1);
    endfunction

    function automatic logic [31:0] byte_mask(input logic [3:0] k);
        logic [31:0] m = '0;
        for (int b = 0; b < 4; b++) if (k[b]) m[8*b +: 8] = 8'hFF;
        return m;
    endfunction

    // Present one beat (called just after a rising edge) until it handshakes.
    task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        bit fired = 1'b0;
        int n = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        while (!fired && n < 5000) begin
            @(negedge axis_clk);
            fired = s_axis_tready;
            @(posedge axis_clk);
            #1;
            n++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        if (!fired) check("beat_timeout", 64'(fired), 64'd1);
    endtask

    // Build a random frame of len bytes (garbage in unused tail bytes) and send it.
    task automatic send_frame(input int len, input bit gaps, input bit drop_en);
        int nb;
        nb = (len + 3) / 4;
        in_q.delete();
        for (int i = 0; i < nb; i++) in_q.push_back($urandom);
        tx_enable = 1'b1;
        for (int i = 0; i < nb; i++) begin
            if (gaps && $urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge axis_clk);
                #1;
            end
            drive_beat(in_q[i], (i == nb - 1) ? keep_of(len) : 4'hF, i == nb - 1);
            if (drop_en && i == 0) tx_enable = 1'b0;
        end
    endtask

    // Model: frames at or above MIN pass unchanged; shorter frames become the
    // zero-extended byte stream, full words only, with at least one pad word
    // after the data, at least MIN bytes long, reported as MIN bytes.
    task automatic check_frame(input int len, input string tag);
        int          n_in, nw, elen, t;
        bit          pad;
        logic [3:0]  lk;
        logic [36:0] got, exp;
        logic [47:0] s;
        n_in = (len + 3) / 4;
        lk   = keep_of(len);
        pad  = (MIN != 0) && (len < MIN);
        nw   = pad ? ((MIN / 4 > n_in + 1) ? MIN / 4 : n_in + 1) : n_in;
        elen = pad ? MIN : len;
        t = 0;
        while (sent_q.size() == 0 && t < 20000) begin
            @(negedge axis_clk);
            t++;
        end
        check({tag, " sent_seen"}, 64'(sent_q.size() != 0), 64'd1);
        if (sent_q.size() == 0) return;
        repeat (3) @(negedge axis_clk);
        check({tag, " sent_pulses"}, 64'(sent_q.size()), 64'd1);
        exp_frames++;
        s = sent_q.pop_front();
        check({tag, " frame_len"}, 64'(s[47:32]), 64'(elen));
        check({tag, " frames_cnt"}, 64'(s[31:0]), 64'(exp_frames));
        check({tag, " sent_delay"}, 64'(sent_dly_q.pop_front()), 64'd1);
        check({tag, " txc_words"}, 64'(txc_q.size()), 64'd6);
        for (int i = 0; i < 6 && txc_q.size() > 0; i++) begin
            got = txc_q.pop_front();
            exp = {(i == 5), 4'hF, (i == 0) ? 32'hA000_0000 : 32'h0};
            check($sformatf("%s txc[%0d]", tag, i), 64'(got), 64'(exp));
        end
        check({tag, " txd_words"}, 64'(txd_q.size()), 64'(nw));
        for (int i = 0; i < nw && txd_q.size() > 0; i++) begin
            got = txd_q.pop_front();
            if (i >= n_in)             exp = {(i == nw - 1), 4'hF, 32'h0};
            else if (pad && i == n_in - 1) exp = {1'b0, 4'hF, in_q[i] & byte_mask(lk)};
            else                       exp = {(i == nw - 1), (i == n_in - 1) ? lk : 4'hF, in_q[i]};
            check($sformatf("%s txd[%0d]", tag, i), 64'(got), 64'(exp));
        end
        txc_q.delete();
        txd_q.delete();
        check({tag, " axis_stable"}, 64'(stab_viol), 64'd0);
        check({tag, " txc_txd_excl"}, 64'(overlap_viol), 64'd0);
        @(posedge axis_clk);
        #1;
    endtask

    initial begin
        axis_aresetn  = 1'b0;
        tx_enable     = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        repeat (4) @(posedge axis_clk);
        #1;

        // Reset state
        check("rst s_tready",   64'(s_axis_tready),     64'd0);
        check("rst txc_valid",  64'(m_axis_txc_tvalid), 64'd0);
        check("rst txd_valid",  64'(m_axis_txd_tvalid), 64'd0);
        check("rst txd_tdata",  64'(m_axis_txd_tdata),  64'd0);
        check("rst frame_sent", 64'(frame_sent),        64'd0);
        check("rst frame_len",  64'(frame_len_bytes),   64'd0);
        check("rst frames_cnt", 64'(frames_sent_cnt),   64'd0);
        axis_aresetn = 1'b1;
        repeat (2) @(posedge axis_clk);
        #1;

        // tx_enable low holds a pending frame off
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'h1234_5678;
        s_axis_tkeep  = 4'hF;
        repeat (10) @(posedge axis_clk);
        #1;
        check("gated s_tready",  64'(s_axis_tready),     64'd0);
        check("gated txc_valid", 64'(m_axis_txc_tvalid), 64'd0);
        check("gated txc_words", 64'(txc_q.size()),      64'd0);
        s_axis_tvalid = 1'b0;

        // 12-byte frame, tx_enable dropped after the first data beat
        send_frame(12, 1'b0, 1'b1);
        check_frame(12, "f12");
        // 62 bytes: no pad, short last keep passes through
        send_frame(62, 1'b0, 1'b0);
        check_frame(62, "f62");
        // 58 bytes: last beat widened, one closing pad word
        send_frame(58, 1'b0, 1'b0);
        check_frame(58, "f58");
        // Exact minimum and one word below it
        send_frame(60, 1'b0, 1'b0);
        check_frame(60, "f60");
        send_frame(56, 1'b0, 1'b0);
        check_frame(56, "f56");

        // Random frames with random backpressure and input gaps
        rnd_rdy = 1'b1;
        for (int f = 0; f < 100; f++) begin
            int len;
            len = int'($urandom_range(20, 1500));
            send_frame(len, 1'b1, 1'b0);
            check_frame(len, $sformatf("rnd%0d_len%0d", f, len));
        end
        check("rnd frames_cnt", 64'(frames_sent_cnt), 64'(exp_frames));
        rnd_rdy = 1'b0;
        repeat (3) @(posedge axis_clk);
        #1;

        // Reset during beat 5 of a 64-byte frame
        in_q.delete();
        for (int i = 0; i < 16; i++) in_q.push_back($urandom);
        tx_enable = 1'b1;
        for (int i = 0; i < 4; i++) drive_beat(in_q[i], 4'hF, 1'b0);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = in_q[4];
        s_axis_tkeep  = 4'hF;
        axis_aresetn  = 1'b0;
        @(posedge axis_clk);
        #1;
        check("midrst txd_valid",  64'(m_axis_txd_tvalid), 64'd0);
        check("midrst txd_tlast",  64'(m_axis_txd_tlast),  64'd0);
        check("midrst txd_tdata",  64'(m_axis_txd_tdata),  64'd0);
        check("midrst txd_tkeep",  64'(m_axis_txd_tkeep),  64'd0);
        check("midrst txc_valid",  64'(m_axis_txc_tvalid), 64'd0);
        check("midrst s_tready",   64'(s_axis_tready),     64'd0);
        check("midrst frame_len",  64'(frame_len_bytes),   64'd0);
        check("midrst frames_cnt", 64'(frames_sent_cnt),   64'd0);
        s_axis_tvalid = 1'b0;
        axis_aresetn  = 1'b1;
        repeat (2) @(posedge axis_clk);
        #1;
        txc_q.delete();
        txd_q.delete();
        sent_q.delete();
        sent_dly_q.delete();
        exp_frames = 0;
        send_frame(20, 1'b0, 1'b0);
        check_frame(20, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_axis_tx_from_rdma
`default_nettype wire

// File: doc/axis_tx_from_rdma.md
Name: axis_tx_from_rdma

Overview:
TX-side adapter: accepts complete Ethernet frames from the RDMA encapsulator on an AXI-Stream slave and drives the AXI Ethernet TX interfaces, s_axis_txc (control) and s_axis_txd (data), per PG138. For each frame, the 6-word TXC control packet is emitted first, then the data beats are passed through a registered stage. Frames shorter than MIN_FRAME_BYTES are zero-padded. Each sent frame is reported with a pulse, its length and a running count.

Parameters:
MIN_FRAME_BYTES, 60, minimum transmitted length excluding FCS; must be a multiple of 4; 0 disables padding.
TXC_FLAG_WORD, 32'hA000_0000, TXC word 0 (normal transmit, no checksum offload).

Ports:
axis_clk  in  1  single clock for all logic
axis_aresetn  in  1  reset, synchronous, active-low
tx_enable  in  1  permits a new frame to start; sampled in IDLE only
s_axis_tdata  in  32  frame data from RDMA encapsulator
s_axis_tkeep  in  4  byte enables, low-aligned contiguous
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  last beat of frame
m_axis_txc_tdata  out  32  TXC control word
m_axis_txc_tkeep  out  4  always 4'hF when valid
m_axis_txc_tvalid  out  1  TXC valid
m_axis_txc_tready  in  1  TXC ready
m_axis_txc_tlast  out  1  high on TXC word 5
m_axis_txd_tdata  out  32  frame data to MAC
m_axis_txd_tkeep  out  4  byte enables to MAC
m_axis_txd_tvalid  out  1  TXD valid
m_axis_txd_tready  in  1  TXD ready
m_axis_txd_tlast  out  1  last beat to MAC
frame_sent  out  1  one-cycle pulse when the final TXD beat handshakes
frame_len_bytes  out  16  transmitted byte count of the last frame, padding included
frames_sent_cnt  out  32  number of frames sent; wraps at 2^32

Behaviour:
- Reset (axis_aresetn=0 at a clock edge): state IDLE; all tvalid, tlast, tdata, tkeep, frame_sent, frame_len_bytes and frames_sent_cnt go to 0; s_axis_tready=0. A reset mid-frame aborts immediately with no tlast emitted; the partial frame is discarded.
- States: IDLE, TXC, DATA, PAD.
- IDLE:
  - s_axis_tready=0.
  - Transition to TXC when tx_enable && s_axis_tvalid. TXC word 0 is valid on the next cycle.
  - The byte counter clears to 0.
- TXC:
  - Emits 6 words: TXC_FLAG_WORD, then five words of 0. tlast is set on word 5.
  - The word index advances only on txc_tvalid && txc_tready.
  - After word 5 handshakes, the state moves to DATA.
- DATA:
  - s_axis_tready = !txd_tvalid || txd_tready (single registered stage, no bubbles).
  - On an input handshake, the output register loads the beat and txd_tvalid=1. With no new input and the output handshaking, txd_tvalid drops.
  - The byte counter adds popcount(tkeep), 0..4.
  - On input tlast:
    - If new_count >= MIN_FRAME_BYTES or padding is disabled, pass the beat unchanged with tlast=1. Go to IDLE once that beat handshakes; s_axis_tready=0 meanwhile.
    - Otherwise emit the beat with tkeep=4'hF, invalid bytes zeroed and tlast=0. Round the count up to a multiple of 4 and go to PAD.
- PAD:
  - s_axis_tready=0.
  - Emits tdata=0, tkeep=F words. The count increases by 4 per handshake.
  - The word that brings the count to MIN_FRAME_BYTES carries tlast=1. After it handshakes, go to IDLE.
- Completion:
  - frame_sent pulses in the cycle after the tlast TXD handshake.
  - frame_len_bytes updates to the final count in the same cycle.
  - frames_sent_cnt increments in the same cycle.
- tx_enable deasserting mid-frame has no effect; the frame completes.
- The byte counter is 16 bits and saturates at 16'hFFFF.
- A zero-length tlast beat (tkeep=0) is counted as 0 bytes and still terminates the frame.
- Output valid/data stay stable while tready is low (AXIS rule); TXC and TXD are never valid in the same cycle.

Decomposition:
- Package axis_tx_pkg holds:
  - TXC_WORDS=6 and the default TXC_FLAG_WORD;
  - the state encoding as localparams;
  - function keep_popcount(4-bit) -> 3-bit.
- No sub-module is warranted: the TXD output register is inline.

Test Plan:
- 12-byte frame (3 beats, tkeep=F) with all readies high -> TXC A0000000,0,0,0,0,0 (tlast on word 6); TXD has 3 data words and 12 zero pad words, with tlast on the 15th; frame_len_bytes=60, frames_sent_cnt=1.
- 62-byte frame (16 beats, last tkeep=4'h3) -> no pad; TXD last tkeep=3 with tlast; frame_len_bytes=62.
- 58-byte frame (last tkeep=4'h3) -> last data beat goes out as tkeep=F with bytes 2-3 zeroed and no tlast; one pad word with tlast follows; frame_len_bytes=60.
- Random txc_tready/txd_tready (50%) plus input tvalid gaps over 100 frames of 20-1500 bytes -> byte-exact data match with no duplication or loss; frames_sent_cnt=100.
- tx_enable=0 with s_axis_tvalid=1 -> s_axis_tready=0 and no TXC output. Raise tx_enable, then drop it during DATA -> the frame completes normally.
- Assert reset during beat 5 of a 64-byte frame -> next cycle all outputs 0 and state IDLE; the next frame sent starts with a clean TXC sequence.
